// File: rtl/des_pkg.sv
// Shared types for the DES fanout enqueuer: task word layout, FSM state encoding,
// neighbour-word field unpacking and header word defaults.
// Pure declarations; no latency or backpressure of its own.
package des_pkg;

    // Task queue word layout shared with the tile task unit.
    localparam int TS_W     = 32;
    localparam int TTYPE_W  = 4;
    localparam int LOCALE_W = 32;
    localparam int ARGS_W   = 32;

    typedef logic [TS_W-1:0] ts_t;

    typedef struct packed {
        logic [ARGS_W-1:0]   args;
        logic [TTYPE_W-1:0]  ttype;
        logic [LOCALE_W-1:0] locale;
        ts_t                 ts;
    } task_t;

    localparam int TQ_WIDTH = $bits(task_t);

    // Default header layout: word 8 holds the edge-offset array base, word 9 the
    // neighbour array base, both expressed in 32-bit words.
    localparam int HDR_OFF_WORD_DEF = 8;
    localparam int HDR_NBR_WORD_DEF = 9;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_HOFF  = 4'd1,
        S_WT_HOFF  = 4'd2,
        S_RD_HNBR  = 4'd3,
        S_WT_HNBR  = 4'd4,
        S_RD_EDGE  = 4'd5,
        S_WT_EDGE  = 4'd6,
        S_RD_NBR   = 4'd7,
        S_WT_NBR   = 4'd8,
        S_ENQ_CONT = 4'd9,
        S_DRAIN    = 4'd10,
        S_DONE     = 4'd11
    } des_fanout_state_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [31:0] port;
    } nbr_fields_t;

    // Neighbour word: [ts_bits-1:0] timestamp, [ts_bits+port_bits-1:ts_bits] port.
    // Math is done at 64 bits so a 32-bit field width still builds a valid mask.
    function automatic nbr_fields_t unpack_nbr(input logic [31:0] word,
                                               input int ts_bits,
                                               input int port_bits);
        logic [63:0] w;
        nbr_fields_t f;
        w      = {32'd0, word};
        f.ts   = 32'(w & ((64'd1 << ts_bits) - 64'd1));
        f.port = 32'((w >> ts_bits) & ((64'd1 << port_bits) - 64'd1));
        return f;
    endfunction

endpackage

// File: rtl/des_fanout_enqueuer.sv
// Purpose: per input task, read the vertex CSR edge range over L1 AXI and emit one child task per
//   neighbour (up to CHUNK), plus one continuation task when neighbours remain.
// Latency: warm bases, no stalls: ap_start -> first TVALID = RD_EDGE + WT_EDGE + RD_NBR + L1 latency.
// Backpressure: TREADY low holds RREADY low while in the neighbour burst, so no beat is lost.
// Ports: ap_* block-level handshake and debug state; task_in/task_out_V_* task I/O (AXIS out);
//   cfg_invalidate forces a header re-read; m_axi_l1_V_* read-only AXI master (write side idle);
//   undo_log_* unused and tied off.
module des_fanout_enqueuer
    import des_pkg::*;
#(
    parameter int CORE_ID             = 0,
    parameter int TILE_ID             = 0,
    parameter int CHUNK               = 7,
    parameter int HDR_OFF_WORD        = HDR_OFF_WORD_DEF,
    parameter int HDR_NBR_WORD        = HDR_NBR_WORD_DEF,
    parameter int TS_BITS             = 24,
    parameter int PORT_BITS           = 2,
    parameter int CHILD_TTYPE         = 0,
    parameter int CONT_TTYPE          = 1,
    parameter int UNDO_LOG_ADDR_WIDTH = 32,
    parameter int UNDO_LOG_DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic [TQ_WIDTH-1:0]     task_in,
    output logic [TQ_WIDTH-1:0]     task_out_V_TDATA,
    output logic                    task_out_V_TVALID,
    input  logic                    task_out_V_TREADY,
    input  logic                    cfg_invalidate,
    output logic                    m_axi_l1_V_ARVALID,
    input  logic                    m_axi_l1_V_ARREADY,
    output logic [31:0]             m_axi_l1_V_ARADDR,
    output logic [7:0]              m_axi_l1_V_ARLEN,
    output logic [2:0]              m_axi_l1_V_ARSIZE,
    input  logic                    m_axi_l1_V_RVALID,
    output logic                    m_axi_l1_V_RREADY,
    input  logic [31:0]             m_axi_l1_V_RDATA,
    input  logic                    m_axi_l1_V_RLAST,
    input  logic                    m_axi_l1_V_RID,
    input  logic [1:0]              m_axi_l1_V_RRESP,
    output logic                    m_axi_l1_V_AWVALID,
    input  logic                    m_axi_l1_V_AWREADY,
    output logic [31:0]             m_axi_l1_V_AWADDR,
    output logic [7:0]              m_axi_l1_V_AWLEN,
    output logic [2:0]              m_axi_l1_V_AWSIZE,
    output logic                    m_axi_l1_V_WVALID,
    input  logic                    m_axi_l1_V_WREADY,
    output logic [31:0]             m_axi_l1_V_WDATA,
    output logic [3:0]              m_axi_l1_V_WSTRB,
    output logic                    m_axi_l1_V_WLAST,
    input  logic                    m_axi_l1_V_BVALID,
    output logic                    m_axi_l1_V_BREADY,
    input  logic [1:0]              m_axi_l1_V_BRESP,
    output logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
    output logic                    undo_log_entry_ap_vld,
    input  logic                    undo_log_entry_ap_rdy,
    output logic [31:0]             ap_state
);

    localparam logic [31:0] CHUNK32 = 32'(CHUNK);

    des_fanout_state_t state;

    logic [31:0] base_off;
    logic [31:0] base_nbr;
    logic        bases_valid;
    logic        inv_pend;      // invalidate seen mid-task: header reads must not re-validate
    logic        err;
    logic [15:0] task_cnt;
    logic [31:0] vid;
    logic [31:0] args_in;
    logic [31:0] start_idx;
    logic [31:0] end_idx;
    logic        edge_second;   // first edge-offset beat already consumed
    logic        more;          // neighbours remain beyond this chunk
    logic [31:0] last_ts;

    task_t       tin;
    task_t       child_t;
    task_t       cont_t;
    nbr_fields_t nf;
    logic [31:0] rem;
    logic [31:0] beats;
    logic        nbr_avail;
    logic        rresp_bad;
    logic        t_hs;

    assign tin       = task_t'(task_in);
    assign rem       = end_idx - start_idx;
    assign beats     = (rem > CHUNK32) ? CHUNK32 : rem;
    assign nbr_avail = start_idx < end_idx;
    assign rresp_bad = m_axi_l1_V_RRESP != 2'b00;
    assign nf        = unpack_nbr(m_axi_l1_V_RDATA, TS_BITS, PORT_BITS);

    always_comb begin
        child_t        = '0;
        child_t.args   = nf.port;
        child_t.ttype  = TTYPE_W'(CHILD_TTYPE);
        child_t.locale = vid;
        child_t.ts     = nf.ts;
        cont_t         = '0;
        cont_t.args    = {args_in[31:16], args_in[15:0] + 16'(CHUNK)};
        cont_t.ttype   = TTYPE_W'(CONT_TTYPE);
        cont_t.locale  = vid;
        cont_t.ts      = last_ts;
    end

    // AR fields are pure decodes of registered state, so they hold steady until ARREADY.
    always_comb begin
        m_axi_l1_V_ARVALID = 1'b0;
        m_axi_l1_V_ARADDR  = 32'd0;
        m_axi_l1_V_ARLEN   = 8'd0;
        case (state)
            S_RD_HOFF: begin
                m_axi_l1_V_ARVALID = 1'b1;
                m_axi_l1_V_ARADDR  = 32'(HDR_OFF_WORD * 4);
            end
            S_RD_HNBR: begin
                m_axi_l1_V_ARVALID = 1'b1;
                m_axi_l1_V_ARADDR  = 32'(HDR_NBR_WORD * 4);
            end
            S_RD_EDGE: begin
                m_axi_l1_V_ARVALID = 1'b1;
                m_axi_l1_V_ARADDR  = base_off + {vid[29:0], 2'b00};
                m_axi_l1_V_ARLEN   = 8'd1;
            end
            S_RD_NBR: begin
                m_axi_l1_V_ARVALID = nbr_avail;
                m_axi_l1_V_ARADDR  = base_nbr + {start_idx[29:0], 2'b00};
                m_axi_l1_V_ARLEN   = 8'(beats - 32'd1);
            end
            default: ;
        endcase
    end

    // Neighbour beats pass straight through to task_out; an errored beat is
    // swallowed (RREADY forced) instead of being forwarded.
    always_comb begin
        task_out_V_TVALID = 1'b0;
        m_axi_l1_V_RREADY = 1'b0;
        case (state)
            S_WT_HOFF, S_WT_HNBR, S_WT_EDGE, S_DRAIN: m_axi_l1_V_RREADY = 1'b1;
            S_WT_NBR: begin
                task_out_V_TVALID = m_axi_l1_V_RVALID && !rresp_bad;
                m_axi_l1_V_RREADY = task_out_V_TREADY || rresp_bad;
            end
            S_ENQ_CONT: task_out_V_TVALID = more;
            default: ;
        endcase
    end

    assign task_out_V_TDATA = (state == S_ENQ_CONT) ? cont_t : child_t;
    assign t_hs             = task_out_V_TVALID && task_out_V_TREADY;

    assign ap_done  = (state == S_DONE);
    assign ap_idle  = (state == S_IDLE);
    assign ap_ready = (state == S_IDLE);
    assign ap_state = {task_cnt, 10'd0, bases_valid, err, state};

    assign m_axi_l1_V_ARSIZE     = 3'b010;
    assign m_axi_l1_V_AWVALID    = 1'b0;
    assign m_axi_l1_V_AWADDR     = 32'd0;
    assign m_axi_l1_V_AWLEN      = 8'd0;
    assign m_axi_l1_V_AWSIZE     = 3'd0;
    assign m_axi_l1_V_WVALID     = 1'b0;
    assign m_axi_l1_V_WDATA      = 32'd0;
    assign m_axi_l1_V_WSTRB      = 4'd0;
    assign m_axi_l1_V_WLAST      = 1'b0;
    assign m_axi_l1_V_BREADY     = 1'b1;
    assign undo_log_entry        = '0;
    assign undo_log_entry_ap_vld = 1'b0;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            base_off    <= 32'd0;
            base_nbr    <= 32'd0;
            bases_valid <= 1'b0;
            inv_pend    <= 1'b0;
            err         <= 1'b0;
            task_cnt    <= 16'd0;
            vid         <= 32'd0;
            args_in     <= 32'd0;
            start_idx   <= 32'd0;
            end_idx     <= 32'd0;
            edge_second <= 1'b0;
            more        <= 1'b0;
            last_ts     <= 32'd0;
        end else begin
            if (t_hs) begin
                task_cnt <= task_cnt + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        vid         <= tin.locale;
                        args_in     <= tin.args;
                        inv_pend    <= 1'b0;
                        edge_second <= 1'b0;
                        state       <= (bases_valid && !cfg_invalidate) ? S_RD_EDGE : S_RD_HOFF;
                    end
                end
                S_RD_HOFF: if (m_axi_l1_V_ARREADY) state <= S_WT_HOFF;
                S_WT_HOFF: begin
                    if (m_axi_l1_V_RVALID) begin
                        if (rresp_bad) begin
                            err         <= 1'b1;
                            bases_valid <= 1'b0;
                            state       <= m_axi_l1_V_RLAST ? S_DONE : S_DRAIN;
                        end else begin
                            base_off <= {m_axi_l1_V_RDATA[29:0], 2'b00};
                            if (m_axi_l1_V_RLAST) state <= S_RD_HNBR;
                        end
                    end
                end
                S_RD_HNBR: if (m_axi_l1_V_ARREADY) state <= S_WT_HNBR;
                S_WT_HNBR: begin
                    if (m_axi_l1_V_RVALID) begin
                        if (rresp_bad) begin
                            err         <= 1'b1;
                            bases_valid <= 1'b0;
                            state       <= m_axi_l1_V_RLAST ? S_DONE : S_DRAIN;
                        end else begin
                            base_nbr <= {m_axi_l1_V_RDATA[29:0], 2'b00};
                            if (m_axi_l1_V_RLAST) begin
                                bases_valid <= !inv_pend;
                                state       <= S_RD_EDGE;
                            end
                        end
                    end
                end
                S_RD_EDGE: if (m_axi_l1_V_ARREADY) state <= S_WT_EDGE;
                S_WT_EDGE: begin
                    if (m_axi_l1_V_RVALID) begin
                        if (rresp_bad) begin
                            err   <= 1'b1;
                            state <= m_axi_l1_V_RLAST ? S_DONE : S_DRAIN;
                        end else begin
                            if (!edge_second) begin
                                start_idx   <= m_axi_l1_V_RDATA + {16'd0, args_in[15:0]};
                                edge_second <= 1'b1;
                            end
                            if (m_axi_l1_V_RLAST) begin
                                end_idx <= m_axi_l1_V_RDATA;
                                state   <= S_RD_NBR;
                            end
                        end
                    end
                end
                S_RD_NBR: begin
                    if (!nbr_avail) begin
                        state <= S_DONE;
                    end else if (m_axi_l1_V_ARREADY) begin
                        more  <= rem > CHUNK32;
                        state <= S_WT_NBR;
                    end
                end
                S_WT_NBR: begin
                    if (m_axi_l1_V_RVALID) begin
                        if (rresp_bad) begin
                            err   <= 1'b1;
                            state <= m_axi_l1_V_RLAST ? S_DONE : S_DRAIN;
                        end else if (task_out_V_TREADY) begin
                            last_ts <= nf.ts;
                            if (m_axi_l1_V_RLAST) state <= S_ENQ_CONT;
                        end
                    end
                end
                S_ENQ_CONT: begin
                    if (!more || task_out_V_TREADY) state <= S_DONE;
                end
                S_DRAIN: begin
                    if (m_axi_l1_V_RVALID && m_axi_l1_V_RLAST) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // Invalidate wins over any re-validation in the same cycle; a task in
            // flight keeps using the bases it already holds.
            if (cfg_invalidate) begin
                bases_valid <= 1'b0;
                if (state != S_IDLE) inv_pend <= 1'b1;
            end
        end
    end

endmodule
